// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
//   state_t    : loader FSM states
//   ERR_*      : err_code encodings
//   LEN_BYTES  : number of length-header bytes in a frame
//   imem_wr_t  : one instruction-memory write request (strobe, byte address, word)
package instr_loader_pkg;

  typedef enum logic [2:0] {
    IDLE, LEN0, LEN1, DATA, CHK, DONE, ERR
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;

  localparam int LEN_BYTES = 2;

  typedef struct packed {
    logic        en;
    logic [31:0] addr;
    logic [31:0] data;
  } imem_wr_t;

endpackage

// File: rtl/instr_loader_byte_packer.sv
// byte_packer: 8->32 big-endian packer.
//   clk, rst_n  : clock, async active-low reset
//   clr         : restart at byte index 0
//   shift_en    : a data byte is being accepted this cycle
//   byte_in     : the byte
//   word_out    : {three held bytes, byte_in}; meaningful when word_valid
//   word_valid  : combinational strobe, high on the cycle byte index 3 is accepted
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_valid
);

  logic [23:0] hold;
  logic [1:0]  idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
      idx  <= '0;
    end else if (clr) begin
      hold <= '0;
      idx  <= '0;
    end else if (shift_en) begin
      hold <= {hold[15:0], byte_in};
      idx  <= idx + 2'd1;     // wraps 3 -> 0 at each word boundary
    end
  end

  // The fourth byte is not stored; it completes the word straight from the input.
  assign word_out   = {hold, byte_in};
  assign word_valid = shift_en && (idx == 2'd3);

endmodule

// File: rtl/instr_loader.sv
// instr_loader: receives a framed byte stream (LEN_HI, LEN_LO, 4*N data bytes,
// XOR checksum byte), packs data into 32-bit big-endian words and writes them
// into the instruction memory at consecutive word-aligned byte addresses.
//   clk, rst_n            : clock, async active-low reset
//   start                 : begin a new load (only from IDLE/DONE/ERR)
//   byte_in/byte_valid/byte_ready : byte stream handshake
//   wr_en/wr_addr/wr_data : instruction memory write port
//   cpu_hold              : keep CPU in reset while loading or after an error
//   done/err/err_code     : load outcome levels
//   words_loaded          : words written in the current/last load
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int          DEPTH     = 128,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CW        = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  output logic          wr_en,
  output logic [31:0]   wr_addr,
  output logic [31:0]   wr_data,
  output logic          cpu_hold,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [CW-1:0] words_loaded
);

  state_t state, nxt;

  imem_wr_t                 wr_q;
  logic [7:0]               csum;
  logic [7:0]               len_hi;
  logic [8*LEN_BYTES-1:0]   len_n;
  logic [8*LEN_BYTES-1:0]   n_q;
  logic                     done_q, err_q, hold_q;
  logic [1:0]               code_q;
  logic [CW-1:0]            wl_q;

  logic        xfer, start_ok, over, last_word, csum_ok;
  logic        pk_valid;
  logic [31:0] pk_word;

  assign byte_ready = (state == LEN0) || (state == LEN1) ||
                      (state == DATA) || (state == CHK);
  assign xfer       = byte_valid && byte_ready;
  assign start_ok   = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign len_n      = {len_hi, byte_in};
  assign over       = 32'(len_n) > 32'(DEPTH);
  assign last_word  = (32'(wl_q) + 32'd1) == 32'(n_q);
  assign csum_ok    = (byte_in == csum);

  byte_packer u_pack (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (start_ok),
    .shift_en   (xfer && (state == DATA)),
    .byte_in    (byte_in),
    .word_out   (pk_word),
    .word_valid (pk_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERR: if (start) nxt = LEN0;
      LEN0:            if (xfer) nxt = LEN1;
      LEN1: if (xfer) begin
        if (over)               nxt = ERR;
        else if (len_n == '0)   nxt = CHK;
        else                    nxt = DATA;
      end
      DATA:            if (pk_valid && last_word) nxt = CHK;
      CHK:             if (xfer) nxt = csum_ok ? DONE : ERR;
      default:         nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '{en: 1'b0, addr: BASE_ADDR, data: 32'd0};
      csum   <= '0;
      len_hi <= '0;
      n_q    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      hold_q <= 1'b0;
      code_q <= ERR_NONE;
      wl_q   <= '0;
    end else begin
      // Write strobe lives for exactly the cycle after the word's last byte;
      // the address steps once that cycle is over.
      wr_q.en <= pk_valid;
      if (pk_valid) wr_q.data <= pk_word;
      if (wr_q.en)  wr_q.addr <= wr_q.addr + 32'd4;

      if (start_ok) begin
        done_q    <= 1'b0;
        err_q     <= 1'b0;
        code_q    <= ERR_NONE;
        wl_q      <= '0;
        csum      <= '0;
        hold_q    <= 1'b1;
        wr_q.addr <= BASE_ADDR;
      end else if (xfer) begin
        case (state)
          LEN0: begin
            csum   <= csum ^ byte_in;
            len_hi <= byte_in;
          end
          LEN1: begin
            csum <= csum ^ byte_in;
            n_q  <= len_n;
            if (over) begin
              err_q  <= 1'b1;
              code_q <= ERR_LEN;
            end
          end
          DATA: begin
            csum <= csum ^ byte_in;
            if (pk_valid) wl_q <= wl_q + CW'(1);
          end
          CHK: begin
            if (csum_ok) begin
              done_q <= 1'b1;
              hold_q <= 1'b0;
            end else begin
              err_q  <= 1'b1;   // hold stays high: a corrupt image never runs
              code_q <= ERR_CSUM;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign wr_en        = wr_q.en;
  assign wr_addr      = wr_q.addr;
  assign wr_data      = wr_q.data;
  assign cpu_hold     = hold_q;
  assign done         = done_q;
  assign err          = err_q;
  assign err_code     = code_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

  localparam int          DEPTH = 128;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    byte_in = 8'h00;
  logic          byte_valid = 1'b0;
  logic          byte_ready, wr_en, cpu_hold, done, err;
  logic [31:0]   wr_addr, wr_data;
  logic [1:0]    err_code;
  logic [CW-1:0] words_loaded;

  instr_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .cpu_hold(cpu_hold), .done(done),
    .err(err), .err_code(err_code), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t        expq[$];
  logic [7:0] frame[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Every write strobe must match the next expected (addr, word) pair.
  always @(negedge clk) begin
    if (rst_n && wr_en === 1'b1) begin
      if (expq.size() == 0) begin
        ncmp++; nfail++;
        $display("FAIL unexpected_write: got addr %h data %h want no write", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = expq.pop_front();
        chk("wr_addr", wr_addr, e.a);
        chk("wr_data", wr_data, e.d);
      end
    end
  end

  function automatic logic [7:0] xor_all(input int upto);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < upto; i++) x ^= frame[i];
    return x;
  endfunction

  // Reference: interpret the frame and predict writes and outcome.
  task automatic model(output logic e_done, output logic e_err,
                       output logic [1:0] e_code, output int e_wl);
    int n;
    n = {frame[0], frame[1]};
    e_done = 1'b0; e_err = 1'b0; e_code = 2'b00; e_wl = 0;
    if (n > DEPTH) begin
      e_err = 1'b1; e_code = 2'b01;
    end else begin
      for (int i = 0; i < n; i++)
        expq.push_back('{BASE + 32'(4*i),
                         {frame[2+4*i], frame[3+4*i], frame[4+4*i], frame[5+4*i]}});
      e_wl = n;
      if (frame[2+4*n] == xor_all(2+4*n)) e_done = 1'b1;
      else begin e_err = 1'b1; e_code = 2'b10; end
    end
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_hold", cpu_hold, 1);
    chk("start_done", done, 0);
    chk("start_err", err, 0);
    chk("start_wl", words_loaded, 0);
  endtask

  task automatic send_frame(input int gap_pct, input bit mid_start);
    for (int i = 0; i < frame.size(); i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        @(negedge clk);
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
        start      = mid_start;
      end
      @(negedge clk);
      byte_valid = 1'b1;
      byte_in    = frame[i];
      start      = mid_start && (i % 3 == 1);
      for (int b = 0; !byte_ready; b++) begin
        if (b > 50) begin
          chk("byte_ready_timeout", 0, 1);
          byte_valid = 1'b0; start = 1'b0;
          return;
        end
        @(negedge clk);
        start = 1'b0;
      end
      @(posedge clk);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic finish_check(input string nm, input logic e_done, input logic e_err,
                              input logic [1:0] e_code, input int e_wl);
    repeat (2) @(negedge clk);
    chk({nm, "_done"}, done, e_done);
    chk({nm, "_err"}, err, e_err);
    chk({nm, "_code"}, err_code, e_code);
    chk({nm, "_wl"}, words_loaded, e_wl);
    chk({nm, "_hold"}, cpu_hold, e_done ? 0 : 1);
    chk({nm, "_ready"}, byte_ready, 0);
    chk({nm, "_pending_writes"}, expq.size(), 0);
  endtask

  task automatic run(input string nm, input int gap_pct, input bit mid_start);
    logic e_done, e_err; logic [1:0] e_code; int e_wl;
    model(e_done, e_err, e_code, e_wl);
    do_start();
    send_frame(gap_pct, mid_start);
    finish_check(nm, e_done, e_err, e_code, e_wl);
  endtask

  task automatic reset_values(input string nm);
    chk({nm, "_ready"}, byte_ready, 0);
    chk({nm, "_wr_en"}, wr_en, 0);
    chk({nm, "_wr_addr"}, wr_addr, BASE);
    chk({nm, "_wr_data"}, wr_data, 0);
    chk({nm, "_hold"}, cpu_hold, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_err"}, err, 0);
    chk({nm, "_code"}, err_code, 0);
    chk({nm, "_wl"}, words_loaded, 0);
  endtask

  task automatic good_frame();
    frame = {8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
    frame.push_back(xor_all(frame.size()));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    reset_values("rst");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", byte_ready, 0);

    // Good 2-word load; the XOR of the ten bytes before the checksum is 0x28.
    good_frame();
    chk("csum_model", frame[10], 8'h28);
    run("good", 0, 1'b0);
    chk("good_done_lit", done, 1);
    chk("good_wl_lit", words_loaded, 2);
    chk("good_last_addr", wr_addr, BASE + 32'd8);

    // Zero-length frame.
    frame = {8'h00, 8'h00, 8'h00};
    run("zero", 0, 1'b0);

    // Length overflow: 129 words into a 128-word memory.
    frame = {8'h00, 8'h81};
    run("over", 0, 1'b0);
    chk("over_code_lit", err_code, 2'b01);

    // Bad checksum on a 1-word frame, then recovery with a good frame.
    frame = {8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    frame.push_back(xor_all(frame.size()) ^ 8'hFF);
    run("badcs", 0, 1'b0);
    chk("badcs_code_lit", err_code, 2'b10);
    good_frame();
    run("recover", 0, 1'b0);

    // Gapped stream with start pulses during the load.
    good_frame();
    run("gapped", 40, 1'b1);

    // Exact boundary: DEPTH words accepted.
    frame = {8'h00, 8'h80};
    for (int i = 0; i < 4*DEPTH; i++) frame.push_back(8'(i * 7 + 3));
    frame.push_back(xor_all(frame.size()));
    run("full", 0, 1'b0);

    // Reset two bytes into the first word: no write, immediate reset values.
    do_start();
    frame = {8'h00, 8'h01, 8'hAA, 8'hBB};
    send_frame(0, 1'b0);
    #2 rst_n = 1'b0;
    #1 reset_values("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    good_frame();
    run("postrst", 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
